fifo_frame_reader: RTL and testbench

Reads words from the output side of a valid/ready FIFO and emits them as framed packets with an end-of-frame marker. Frames close after FRAME_LEN words or, when the stream goes idle, after a timeout. One word is always held back so that `last` can be attached to the correct beat. It sits directly downstream of the distributed FIFOs in the MIMO datapath and feeds packet-oriented consumers.

---
 rtl/fifo_frame_reader.sv | 100 ++++++++++
 tb/tb_fifo_frame_reader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_frame_reader.sv
// fifo_frame_reader: frames FIFO words into packets, holding one word back so last lands on the right beat.
// Idle-timeout flush of partial frames is enabled by defining FIFO_FRAME_READER_TIMEOUT_EN.
module fifo_frame_reader #(
   parameter int WIDTH     = 8,
   parameter int FRAME_LEN = 16,
   parameter int TIMEOUT   = 64
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic [WIDTH-1:0] i_in_data,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   output logic [WIDTH-1:0] o_out_data,
   output logic             o_out_valid,
   output logic             o_out_last,
   input  logic             i_out_ready,
   output logic             o_flush
);
   localparam int BW = $clog2(FRAME_LEN);
   localparam logic [BW-1:0] BEAT_END = BW'(FRAME_LEN - 1);
   typedef enum logic [1:0] {ST_INIT, ST_EMPTY, ST_HOLD, ST_LAST} state_t;
   state_t state_q, state_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic [BW-1:0] beat_q, beat_d;
   logic flush_q, flush_d;
   logic idle_expired;
`ifdef FIFO_FRAME_READER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] timer_q, timer_d;
   assign idle_expired = timer_q == TW'(TIMEOUT - 1);
   // counts only while a partial frame sits idle; a stalled last beat freezes it
   always_comb begin
      timer_d = (state_q == ST_HOLD && !i_in_valid) ? timer_q + 1'b1 :
                (state_q == ST_LAST && !(i_out_ready && i_in_valid)) ? timer_q : '0;
   end
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) timer_q <= '0;
      else timer_q <= timer_d;
   end
`else
   assign idle_expired = 1'b0;
`endif
   always_comb begin
      state_d = state_q;
      hold_d = hold_q;
      beat_d = beat_q;
      flush_d = 1'b0;
      o_in_ready = 1'b0;
      o_out_valid = 1'b0;
      o_out_last = 1'b0;
      case (state_q)
         ST_INIT: state_d = ST_EMPTY;
         ST_EMPTY: begin
            o_in_ready = 1'b1;
            if (i_in_valid) begin
               hold_d = i_in_data;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            // the held word is only offered when a successor exists to replace it
            o_out_valid = i_in_valid;
            o_in_ready = i_out_ready;
            if (i_in_valid && i_out_ready) begin
               hold_d = i_in_data;
               beat_d = beat_q + 1'b1;
               state_d = (beat_d == BEAT_END) ? ST_LAST : ST_HOLD;
            end else if (!i_in_valid && idle_expired) begin
               state_d = ST_LAST;
               flush_d = 1'b1;
            end
         end
         default: begin
            o_out_valid = 1'b1;
            o_out_last = 1'b1;
            o_in_ready = i_out_ready;
            if (i_out_ready) begin
               beat_d = '0;
               state_d = i_in_valid ? ST_HOLD : ST_EMPTY;
               hold_d = i_in_valid ? i_in_data : hold_q;
            end
         end
      endcase
   end
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_q <= ST_INIT;
         hold_q <= '0;
         beat_q <= '0;
         flush_q <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q <= hold_d;
         beat_q <= beat_d;
         flush_q <= flush_d;
      end
   end
   assign o_out_data = hold_q;
   assign o_flush = flush_q;
endmodule

// File: tb/tb_fifo_frame_reader.sv
// tb_fifo_frame_reader: scoreboard plus table-driven checks for fifo_frame_reader (FRAME_LEN=4, TIMEOUT=8).
module tb_fifo_frame_reader;
   localparam int W = 8, FL = 4, TO = 8;
   logic clk = 1'b0, rst = 1'b0;
   logic [W-1:0] i_in_data = '0;
   logic i_in_valid = 1'b0, i_out_ready = 1'b0;
   logic o_in_ready, o_out_valid, o_out_last, o_flush;
   logic [W-1:0] o_out_data;

   fifo_frame_reader #(.WIDTH(W), .FRAME_LEN(FL), .TIMEOUT(TO)) dut (
      .i_clock(clk), .i_reset(rst), .i_in_data(i_in_data), .i_in_valid(i_in_valid),
      .o_in_ready(o_in_ready), .o_out_data(o_out_data), .o_out_valid(o_out_valid),
      .o_out_last(o_out_last), .i_out_ready(i_out_ready), .o_flush(o_flush));

   always #5 clk = ~clk;

   typedef struct packed {logic v; logic [7:0] d; logic r; logic ev; logic el; logic [7:0] ed; logic er; logic ef;} vec_t;
   typedef struct {logic [7:0] d; logic l;} exp_t;
   exp_t exp_q[$];
   logic [7:0] src_q[$];
   int checks = 0, errors = 0, cyc_n = 0, flushes = 0, flush_at = -1;
   int emit_at[int];
   logic popped;
`ifdef FIFO_FRAME_READER_TIMEOUT_EN
   localparam bit TMO = 1'b1;
`else
   localparam bit TMO = 1'b0;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic r);
      i_in_valid = v;
      i_in_data = d;
      i_out_ready = r;
   endtask

   task automatic tick();
      exp_t e;
      #4;
      popped = i_in_valid && o_in_ready;
      if (o_flush) begin
         flushes++;
         flush_at = cyc_n;
      end
      if (o_out_valid && i_out_ready) begin
         emit_at[int'(o_out_data)] = cyc_n;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out actual=%0h required=none", o_out_data);
         end else begin
            e = exp_q.pop_front();
            chk("out_data", {24'h0, o_out_data}, {24'h0, e.d});
            chk("out_last", {31'h0, o_out_last}, {31'h0, e.l});
         end
      end
      cyc_n++;
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input logic v, input logic [7:0] d, input logic r);
      drive(v, d, r);
      tick();
   endtask

   task automatic src_step(input logic r);
      logic v;
      logic [7:0] d;
      v = src_q.size() > 0;
      d = v ? src_q[0] : 8'h00;
      cyc(v, d, r);
      if (popped && src_q.size() > 0) void'(src_q.pop_front());
   endtask

   task automatic put(input logic [7:0] d, input logic l);
      src_q.push_back(d);
      exp_q.push_back('{d: d, l: l});
   endtask

   task automatic run_until_empty(input string name, input int bound);
      int n;
      n = 0;
      while ((exp_q.size() > 0 || src_q.size() > 0) && n < bound) begin
         src_step(1'b1);
         n++;
      end
      chk({name, "_drained"}, exp_q.size() + src_q.size(), 0);
   endtask

   task automatic chk_zero(input string name);
      chk({name, "_valid"}, {31'h0, o_out_valid}, 0);
      chk({name, "_ready"}, {31'h0, o_in_ready}, 0);
      chk({name, "_last"}, {31'h0, o_out_last}, 0);
      chk({name, "_data"}, {24'h0, o_out_data}, 0);
      chk({name, "_flush"}, {31'h0, o_flush}, 0);
   endtask

   initial begin
      vec_t tbl[16];
      int f0;
      #1 rst = 1'b1;
      #1 chk_zero("reset");
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      chk("init_ready", {31'h0, o_in_ready}, 0);
      cyc(1'b0, 8'h00, 1'b1);
      chk("empty_ready", {31'h0, o_in_ready}, 1);

      for (int i = 0; i < 8; i++) put(8'h10 + 8'(i), i == 3 || i == 7);
      run_until_empty("stream", 40);
      chk("stream_no_bubble", emit_at[8'h17] - emit_at[8'h10], 7);

      f0 = flushes;
      put(8'hA0, 1'b0);
      if (TMO) begin
         put(8'hA1, 1'b1);
         run_until_empty("timeout", 40);
         chk("timeout_flushes", flushes - f0, 1);
         chk("timeout_latency", emit_at[8'hA1] - (emit_at[8'hA0] + 1), TO);
         chk("flush_with_last", flush_at, emit_at[8'hA1]);
      end else begin
         put(8'hA1, 1'b0);
         repeat (30) src_step(1'b1);
         chk("idle_hold_pending", exp_q.size(), 1);
         put(8'hA2, 1'b0);
         put(8'hA3, 1'b1);
         run_until_empty("no_timeout", 20);
         chk("no_timeout_flushes", flushes - f0, 0);
      end
      for (int i = 0; i < 4; i++) put(8'hB0 + 8'(i), i == 3);
      run_until_empty("after_idle", 20);

      tbl[0] = '{1'b1, 8'hC0, 1'b1, 1'b0, 1'b0, 8'hB3, 1'b1, 1'b0};
      tbl[1] = '{1'b1, 8'hC1, 1'b1, 1'b1, 1'b0, 8'hC0, 1'b1, 1'b0};
      tbl[2] = '{1'b1, 8'hC2, 1'b1, 1'b1, 1'b0, 8'hC1, 1'b1, 1'b0};
      tbl[3] = '{1'b1, 8'hC3, 1'b1, 1'b1, 1'b0, 8'hC2, 1'b1, 1'b0};
      for (int i = 4; i < 14; i++) tbl[i] = '{1'b1, 8'hD0, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0};
      tbl[14] = '{1'b1, 8'hD0, 1'b1, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0};
      tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hD0, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) exp_q.push_back('{d: 8'hC0 + 8'(i), l: i == 3});
      f0 = flushes;
      for (int i = 0; i < 16; i++) begin
         drive(tbl[i].v, tbl[i].d, tbl[i].r);
         #3;
         chk($sformatf("tbl%0d_valid", i), {31'h0, o_out_valid}, {31'h0, tbl[i].ev});
         chk($sformatf("tbl%0d_last", i), {31'h0, o_out_last}, {31'h0, tbl[i].el});
         chk($sformatf("tbl%0d_data", i), {24'h0, o_out_data}, {24'h0, tbl[i].ed});
         chk($sformatf("tbl%0d_ready", i), {31'h0, o_in_ready}, {31'h0, tbl[i].er});
         chk($sformatf("tbl%0d_flush", i), {31'h0, o_flush}, {31'h0, tbl[i].ef});
         tick();
      end
      chk("stall_flushes", flushes - f0, 0);
      exp_q.push_back('{d: 8'hD0, l: 1'b0});
      put(8'hD1, 1'b0);
      put(8'hD2, 1'b0);
      put(8'hD3, 1'b1);
      run_until_empty("stall_tail", 20);

      f0 = flushes;
      put(8'hE0, 1'b0);
      put(8'hE1, 1'b0);
      src_step(1'b1);
      src_step(1'b1);
      repeat (TO - 1) cyc(1'b0, 8'h00, 1'b1);
      put(8'hE2, 1'b0);
      put(8'hE3, 1'b1);
      run_until_empty("collide", 20);
      chk("collide_flushes", flushes - f0, 0);

      put(8'hF0, 1'b0);
      put(8'hF1, 1'b0);
      src_q.push_back(8'hF2);
      repeat (3) src_step(1'b1);
      chk("pre_reset_emitted", exp_q.size() + src_q.size(), 0);
      drive(1'b0, 8'h00, 1'b1);
      #2 rst = 1'b1;
      #1 chk_zero("mid_reset");
      @(posedge clk);
      #1 rst = 1'b0;
      cyc(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 4; i++) put(8'h60 + 8'(i), i == 3);
      run_until_empty("post_reset", 20);
      chk("total_flushes", flushes, TMO ? 1 : 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
